// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: word width,
// default geometry/timing and the responder state encoding.
package mem_pkg;

    localparam int WORD_W    = 32;
    localparam int DEPTH_DEF = 64;
    localparam int WAIT_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one combinational read
// port, every word cleared by the asynchronous reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] words [DEPTH];

    // Clear all words on reset, otherwise write one word when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                words[i] <= '0;
            end
        end else if (we) begin
            words[waddr] <= wdata;
        end
    end

    assign rdata = words[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Processor-facing data memory: accepts one read or write at a time,
// inserts WAIT wait cycles, then pulses ready for one cycle. Bad
// requests (read+write, misaligned, out of range) answer after a single
// cycle with err set and touch nothing.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WAIT  = WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              op_wr;
    logic              err_q;
    logic [AW-1:0]     addr_q;
    logic [WORD_W-1:0] wdata_q;

    logic              req;
    logic              req_bad;
    logic              accept;
    logic              load_rd;
    logic              mem_we;
    logic [AW-1:0]     raddr;
    logic [WORD_W-1:0] rd_word;

    assign req     = mem_read | mem_write;
    // Power-of-two depth: out of range means any bit above the index is set
    assign req_bad = (mem_read & mem_write) | (addr[1:0] != 2'b00) | (|addr[31:AW+2]);
    assign accept  = (state == IDLE) && req;

    // In IDLE the live address feeds the read port so a zero-wait read can
    // capture its word on the accepting edge; afterwards the latched one.
    assign raddr   = (state == IDLE) ? addr[AW+1:2] : addr_q;

    // rdata is captured on the edge that enters RESP for a good read
    assign load_rd = (accept && !req_bad && !mem_write && (WAIT == 0)) ||
                     ((state == BUSY) && (cnt == 4'd0) && !op_wr);

    // The write lands on the edge that leaves RESP
    assign mem_we  = (state == RESP) && op_wr && !err_q;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (raddr),
        .rdata (rd_word)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: errors and zero-wait requests skip BUSY
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req) state_nxt = (req_bad || (WAIT == 0)) ? RESP : BUSY;
            BUSY: if (cnt == 4'd0) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: ready only in RESP, err qualified by ready
    always_comb begin
        ready = (state == RESP);
        err   = (state == RESP) && err_q;
    end

    // Capture the request on accept; inputs are ignored until back in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_wr   <= mem_write;
            err_q   <= req_bad;
            addr_q  <= addr[AW+1:2];
            wdata_q <= wdata;
        end
    end

    // Wait counter: loaded on a good accept, counts down while BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (accept && !req_bad) begin
            cnt <= CNT_INIT;
        end else if ((state == BUSY) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Read data register: holds until the next successful read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rdata <= '0;
        else if (load_rd) rdata <= rd_word;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT=2 and WAIT=0),
// a transaction-level model predicting the ready cycle, err and rdata,
// and a single per-cycle compare process.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd [2];
    logic        wr [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] rdat [2];
    logic        rdy [2];
    logic        er [2];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(64), .WAIT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd[0]), .mem_write(wr[0]),
        .addr(ad[0]), .wdata(wd[0]), .rdata(rdat[0]), .ready(rdy[0]), .err(er[0])
    );

    data_mem_responder #(.DEPTH(64), .WAIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd[1]), .mem_write(wr[1]),
        .addr(ad[1]), .wdata(wd[1]), .rdata(rdat[1]), .ready(rdy[1]), .err(er[1])
    );

    // Model state
    int          waitc [2] = '{2, 0};
    logic [31:0] mmem [2][64];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    // Transaction records written by the driver, consumed by the checker
    int          wr_idx [2] = '{0, 0};
    int          rd_idx [2] = '{0, 0};
    int          t_cyc [2][32];
    int          t_acc [2][32];
    bit          t_err [2][32];
    bit          t_rd [2][32];
    bit          t_abort [2][32];
    logic [31:0] t_rdata [2][32];
    int          t_lit_lat [2][32];
    logic [31:0] t_lit_val [2][32];
    bit          t_lit_en [2][32];
    logic [31:0] m_rdata [2] = '{32'h0, 32'h0};

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, cyc, act, exp);
        end
    endtask

    // Per-cycle compare, sampled 1 time unit after each rising edge
    always begin
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            bit exp_rdy;
            int k;
            exp_rdy = 1'b0;
            if (!rst_n) begin
                m_rdata[d] = 32'h0;
                chk("rst_ready", d, 32'(rdy[d]), 32'h0);
                chk("rst_err", d, 32'(er[d]), 32'h0);
                chk("rst_rdata", d, rdat[d], 32'h0);
            end else begin
                while (rd_idx[d] < wr_idx[d] && t_abort[d][rd_idx[d]]) rd_idx[d]++;
                k = rd_idx[d];
                if (k < wr_idx[d] && t_cyc[d][k] == cyc) exp_rdy = 1'b1;
                if (exp_rdy && t_rd[d][k]) m_rdata[d] = t_rdata[d][k];
                chk("ready", d, 32'(rdy[d]), 32'(exp_rdy));
                chk("err", d, 32'(er[d]), 32'(exp_rdy && t_err[d][k]));
                chk("rdata", d, rdat[d], m_rdata[d]);
                if (exp_rdy) begin
                    chk("latency_lit", d, 32'(cyc - t_acc[d][k] + 1), 32'(t_lit_lat[d][k]));
                    if (t_lit_en[d][k]) chk("rdata_lit", d, rdat[d], t_lit_val[d][k]);
                    rd_idx[d]++;
                end
            end
        end
    end

    // Drive one request, record its predicted outcome, hold until ready.
    // With abort set, reset is pulsed in the first BUSY cycle instead.
    task automatic issue(input int d, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] din, input int lit_lat,
                         input logic [31:0] lit_val, input bit lit_en, input bit abort);
        bit e;
        int lat;
        int i;
        @(negedge clk);
        rst_n = 1'b1;
        rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = din;
        e   = (r && w) || (a[1:0] != 2'b00) || ((a >> 2) >= 32'd64);
        lat = e ? 1 : waitc[d] + 1;
        i   = wr_idx[d];
        t_acc[d][i]     = cyc + 1;
        t_cyc[d][i]     = cyc + lat;
        t_err[d][i]     = e;
        t_rd[d][i]      = r && !e;
        t_rdata[d][i]   = (r && !e) ? mmem[d][a[7:2]] : 32'h0;
        t_lit_lat[d][i] = lit_lat;
        t_lit_val[d][i] = lit_val;
        t_lit_en[d][i]  = lit_en;
        t_abort[d][i]   = abort;
        wr_idx[d]++;
        if (abort) begin
            @(negedge clk);
            rst_n = 1'b0;
            rd[d] = 1'b0; wr[d] = 1'b0;
            for (int x = 0; x < 2; x++)
                for (int y = 0; y < 64; y++) mmem[x][y] = 32'h0;
            return;
        end
        if (w && !e) mmem[d][a[7:2]] = din;
        while (cyc < t_cyc[d][i]) @(negedge clk);
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = 32'h0; wd[d] = 32'h0;
            for (int y = 0; y < 64; y++) mmem[d][y] = 32'h0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // dut0, WAIT=2
        issue(0, 0, 1, 32'h10, 32'hDEADBEEF, 3, 32'h0, 0, 0);
        issue(0, 1, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1, 0);
        issue(0, 1, 0, 32'h02, 32'h0, 1, 32'hDEADBEEF, 1, 0);
        issue(0, 1, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1, 0);
        issue(0, 0, 1, 32'h100, 32'h11111111, 1, 32'hDEADBEEF, 1, 0);
        issue(0, 1, 1, 32'h0, 32'hFFFFFFFF, 1, 32'hDEADBEEF, 1, 0);
        issue(0, 1, 0, 32'h0, 32'h0, 3, 32'h0, 1, 0);
        issue(0, 1, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1, 0);
        issue(0, 0, 1, 32'h13, 32'h22222222, 1, 32'hDEADBEEF, 1, 0);
        issue(0, 1, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1, 0);
        issue(0, 0, 1, 32'h0, 32'hA5A5A5A5, 3, 32'h0, 0, 0);
        issue(0, 1, 0, 32'h0, 32'h0, 3, 32'hA5A5A5A5, 1, 0);
        issue(0, 0, 1, 32'hFC, 32'h0BADF00D, 3, 32'h0, 0, 0);
        issue(0, 1, 0, 32'hFC, 32'h0, 3, 32'h0BADF00D, 1, 0);
        // write aborted by reset during BUSY, then read back zero
        issue(0, 0, 1, 32'h4, 32'h12345678, 3, 32'h0, 0, 1);
        issue(0, 1, 0, 32'h4, 32'h0, 3, 32'h0, 1, 0);
        issue(0, 1, 0, 32'hFC, 32'h0, 3, 32'h0, 1, 0);

        // dut1, WAIT=0
        issue(1, 0, 1, 32'h4, 32'hCAFEF00D, 1, 32'h0, 0, 0);
        issue(1, 1, 0, 32'h0, 32'h0, 1, 32'h0, 1, 0);
        issue(1, 1, 0, 32'h4, 32'h0, 1, 32'hCAFEF00D, 1, 0);
        issue(1, 1, 0, 32'h0, 32'h0, 1, 32'h0, 1, 0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
